mux_n_pipe: RTL and testbench
=============================

// Module: mux_n_pipe
// PURPOSE
//  N-input, WIDTH-bit selector with a registered, flow-controlled output stage.
//  Successor to the combinational 3:1 datapath mux. Generalises the input
//  count to N and adds valid/ready handshaking on both sides.
//  Adds a 2-entry output buffer so the upstream and downstream stages decouple
//  with full throughput. Illegal selects produce defined data (zero) plus
//  error flags, never X.
// PARAMETERS
//  WIDTH  8  data width of each input channel and of y
//  N      3  number of input channels, N>=2
//  SELW   $clog2(N) (localparam)  width of select s
// PORTS
//  clk        in   1          rising-edge clock
//  reset      in   1          asynchronous reset, active-low (0 = reset)
//  d          in   N*WIDTH    channel i at d[i*WIDTH +: WIDTH]
//  s          in   SELW       binary channel select, sampled with in_valid
//  in_valid   in   1          upstream offers {d[s], s} this cycle
//  in_ready   out  1          buffer can accept this cycle
//  y          out  WIDTH      head-of-buffer data
//  out_valid  out  1          y/out_err hold a valid entry
//  out_ready  in   1          downstream accepts head this cycle
//  out_err    out  1          head entry was captured with s>=N
//  sel_err    out  1          sticky: any illegal select accepted since clear
//  err_clr    in   1          synchronous clear of sel_err
// BEHAVIOUR
//  - Storage: 2 entries {data[WIDTH], err}, a 2-bit count (0..2), rd/wr ptrs.
//  - Reset (reset==0, asynchronous): count=0, ptrs=0, entries=0, sel_err=0.
//    Hence out_valid=0, y=0, out_err=0.
//  - in_ready = (count!=2). It is combinational from count only and does NOT
//    depend on out_ready, so there is no ready->ready path.
//  - push = in_valid & in_ready; pop = out_valid & out_ready.
//  - Push captures data = (s<N) ? d[s*WIDTH +: WIDTH] : '0 and err = (s>=N).
//  - Latency: entry pushed at edge k appears on y/out_valid after edge k
//    (same edge if buffer was empty). No combinational d->y path.
//  - out_valid = (count!=0). y and out_err come from entry[rd_ptr] when valid.
//    y and out_err are forced to 0 when count==0.
//  - count update:
//      push&!pop -> +1
//      pop&!push -> -1
//      push&pop  -> unchanged; write and read happen on different entries.
//  - Full (count==2): in_ready=0. A pop that cycle frees one slot, visible next
//    cycle; push is ignored even if in_valid=1.
//  - Empty (count==0): out_ready is ignored; no underflow.
//  - Pointers are 1 bit and wrap 1->0 naturally.
//  - Entries stay in order; data is never dropped or duplicated.
//  - sel_err: set on the edge of any push with s>=N. Cleared by err_clr=1.
//    If a set and err_clr occur in the same cycle, set wins.
//  - An illegal-select entry still occupies a slot and must be popped normally.
//  - Reset mid-operation discards all buffered entries immediately.
//    First push after release behaves as from empty.
//  - s and d are don't-care when in_valid=0. Outputs never show X once out of
//    reset.
// TESTING
//  1 Reset: hold reset=0 with random inputs -> out_valid=0, y=0, sel_err=0,
//    in_ready=1.
//  2 Basic select, WIDTH=8,N=3: d={2,8,6} (ch0=6,ch1=8,ch2=2), out_ready=1;
//    push s=0,1,2 on consecutive cycles -> y=6,8,2 on the following cycles,
//    out_valid continuous.
//  3 Backpressure: out_ready=0; push s=1 then s=2 -> count=2, in_ready=0.
//    A third push with s=0 is ignored. Then out_ready=1 -> y=8 then 2,
//    in_ready returns 1 one cycle after the first pop.
//  4 Illegal select: push s=3 -> y=0, out_err=1, sel_err=1. Next push s=0 ->
//    y=6, out_err=0, sel_err stays 1. Assert err_clr alone -> sel_err=0.
//    Same cycle as another s=3 push -> sel_err stays 1.
//  5 Full throughput: in_valid=out_ready=1 for 20 cycles, s cycling 0,1,2 ->
//    one entry per cycle, order preserved. Scoreboard matches, count<=1
//    throughout.
//  6 Reset mid-stream: with count=2, pulse reset=0 between edges -> out_valid
//    drops immediately. After release, a push s=2 gives y=2 as the only entry.
//    Repeat with N=5, WIDTH=16 (s=5..7 illegal).

Source files
------------

// File: rtl/mux_n_pipe_if.sv
// Handshake/data bundle for mux_n_pipe: upstream select side and downstream output side.
// The slave modport is the mux itself; the master modport is whatever drives and consumes it.
interface mux_n_pipe_if #(
    parameter int WIDTH = 8,
    parameter int N     = 3
);
    localparam int SELW = $clog2(N);

    logic [N*WIDTH-1:0] d;
    logic [SELW-1:0]    s;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   y;
    logic               out_valid;
    logic               out_ready;
    logic               out_err;
    logic               sel_err;
    logic               err_clr;

    modport slave (
        input  d, s, in_valid, out_ready, err_clr,
        output in_ready, y, out_valid, out_err, sel_err
    );

    modport master (
        output d, s, in_valid, out_ready, err_clr,
        input  in_ready, y, out_valid, out_err, sel_err
    );
endinterface

// File: rtl/mux_n_pipe.sv
// N-input WIDTH-bit selector feeding a 2-entry valid/ready output buffer.
// Illegal selects push a zero entry tagged with an error bit and set a sticky flag.
module mux_n_pipe #(
    parameter int WIDTH = 8,
    parameter int N     = 3
) (
    input  logic           clk,
    input  logic           reset,
    mux_n_pipe_if.slave    bus
);
    localparam int SELW = $clog2(N);

    // Handshake: a transfer happens on a rising edge where valid & ready are both 1;
    // in_ready depends only on the fill level, never on out_ready.
    logic [WIDTH-1:0] r_data [2];
    logic             r_err  [2];
    logic [1:0]       r_count;
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic             r_sel_err;

    logic [WIDTH-1:0] w_data;
    logic             w_sel_ok;
    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_push;
    logic             w_pop;

    always_comb begin
        w_data = '0;
        for (int i = 0; i < N; i++) begin
            if (bus.s == SELW'(i)) begin
                w_data = bus.d[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_sel_ok    = (32'(bus.s) < 32'(N));
    assign w_in_ready  = (r_count != 2'd2);
    assign w_out_valid = (r_count != 2'd0);
    assign w_push      = bus.in_valid & w_in_ready;
    assign w_pop       = w_out_valid & bus.out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_data[0] <= '0;
            r_data[1] <= '0;
            r_err[0]  <= 1'b0;
            r_err[1]  <= 1'b0;
            r_count   <= 2'd0;
            r_wr_ptr  <= 1'b0;
            r_rd_ptr  <= 1'b0;
            r_sel_err <= 1'b0;
        end else begin
            if (w_push) begin
                r_data[r_wr_ptr] <= w_sel_ok ? w_data : '0;
                r_err[r_wr_ptr]  <= ~w_sel_ok;
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
            // A new illegal push in the same cycle as a clear keeps the flag set.
            if (w_push && !w_sel_ok) begin
                r_sel_err <= 1'b1;
            end else if (bus.err_clr) begin
                r_sel_err <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.y         = w_out_valid ? r_data[r_rd_ptr] : '0;
    assign bus.out_err   = w_out_valid ? r_err[r_rd_ptr]  : 1'b0;
    assign bus.sel_err   = r_sel_err;
endmodule

// File: tb/tb_mux_n_pipe.sv
// Directed bench for mux_n_pipe: an 8-bit/3-way instance and a 16-bit/5-way instance.
module tb_mux_n_pipe;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;
    logic [7:0] exp_q[$];

    mux_n_pipe_if #(.WIDTH(8),  .N(3)) b0 ();
    mux_n_pipe_if #(.WIDTH(16), .N(5)) b1 ();

    mux_n_pipe #(.WIDTH(8),  .N(3)) u0 (.clk(clk), .reset(reset), .bus(b0.slave));
    mux_n_pipe #(.WIDTH(16), .N(5)) u1 (.clk(clk), .reset(reset), .bus(b1.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_u0();
        b0.in_valid  = 1'b0;
        b0.out_ready = 1'b0;
        b0.err_clr   = 1'b0;
        b0.s         = '0;
        b0.d         = {8'd2, 8'd8, 8'd6};
    endtask

    task automatic idle_u1();
        b1.in_valid  = 1'b0;
        b1.out_ready = 1'b0;
        b1.err_clr   = 1'b0;
        b1.s         = '0;
        b1.d         = {16'h4444, 16'h3333, 16'h2222, 16'h1111, 16'h0aaa};
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;

        // Reset held low with random inputs
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            b0.in_valid  = 1'($urandom_range(0, 1));
            b0.out_ready = 1'($urandom_range(0, 1));
            b0.err_clr   = 1'($urandom_range(0, 1));
            b0.s         = 2'($urandom_range(0, 3));
            b0.d         = 24'($urandom);
            b1.in_valid  = 1'($urandom_range(0, 1));
            b1.out_ready = 1'($urandom_range(0, 1));
            b1.err_clr   = 1'($urandom_range(0, 1));
            b1.s         = 3'($urandom_range(0, 7));
            b1.d         = 80'($urandom);
            tick();
        end
        check("rst_out_valid", 32'(b0.out_valid), 32'd0);
        check("rst_y",         32'(b0.y),         32'd0);
        check("rst_out_err",   32'(b0.out_err),   32'd0);
        check("rst_sel_err",   32'(b0.sel_err),   32'd0);
        check("rst_in_ready",  32'(b0.in_ready),  32'd1);
        check("rst_u1_valid",  32'(b1.out_valid), 32'd0);
        idle_u0();
        idle_u1();
        tick();
        reset = 1'b1;
        tick();
        check("post_rst_valid", 32'(b0.out_valid), 32'd0);

        // Basic select, streaming
        b0.out_ready = 1'b1;
        b0.in_valid  = 1'b1;
        b0.s = 2'd0; tick();
        check("basic_y0", 32'(b0.y), 32'd6);
        check("basic_v0", 32'(b0.out_valid), 32'd1);
        b0.s = 2'd1; tick();
        check("basic_y1", 32'(b0.y), 32'd8);
        check("basic_v1", 32'(b0.out_valid), 32'd1);
        b0.s = 2'd2; tick();
        check("basic_y2", 32'(b0.y), 32'd2);
        check("basic_v2", 32'(b0.out_valid), 32'd1);
        b0.in_valid = 1'b0; tick();
        check("basic_drain_v", 32'(b0.out_valid), 32'd0);
        check("basic_drain_y", 32'(b0.y), 32'd0);

        // Backpressure and full buffer
        b0.out_ready = 1'b0;
        b0.in_valid  = 1'b1;
        b0.s = 2'd1; tick();
        check("bp_y_one",     32'(b0.y), 32'd8);
        check("bp_ready_one", 32'(b0.in_ready), 32'd1);
        b0.s = 2'd2; tick();
        check("bp_ready_full", 32'(b0.in_ready), 32'd0);
        check("bp_y_full",     32'(b0.y), 32'd8);
        b0.s = 2'd0; tick();
        check("bp_ignored_ready", 32'(b0.in_ready), 32'd0);
        check("bp_ignored_y",     32'(b0.y), 32'd8);
        b0.in_valid  = 1'b0;
        b0.out_ready = 1'b1;
        tick();
        check("bp_pop1_y",     32'(b0.y), 32'd2);
        check("bp_pop1_ready", 32'(b0.in_ready), 32'd1);
        check("bp_pop1_valid", 32'(b0.out_valid), 32'd1);
        tick();
        check("bp_pop2_valid", 32'(b0.out_valid), 32'd0);

        // Illegal select and sticky error
        b0.in_valid = 1'b1;
        b0.s = 2'd3; tick();
        check("ill_y",       32'(b0.y), 32'd0);
        check("ill_out_err", 32'(b0.out_err), 32'd1);
        check("ill_valid",   32'(b0.out_valid), 32'd1);
        check("ill_sel_err", 32'(b0.sel_err), 32'd1);
        b0.s = 2'd0; tick();
        check("ill_next_y",       32'(b0.y), 32'd6);
        check("ill_next_out_err", 32'(b0.out_err), 32'd0);
        check("ill_next_sticky",  32'(b0.sel_err), 32'd1);
        b0.in_valid = 1'b0;
        b0.err_clr  = 1'b1;
        tick();
        check("clr_sel_err", 32'(b0.sel_err), 32'd0);
        check("clr_valid",   32'(b0.out_valid), 32'd0);
        b0.in_valid = 1'b1;
        b0.s = 2'd3;
        tick();
        check("clr_vs_set_sel_err", 32'(b0.sel_err), 32'd1);
        check("clr_vs_set_out_err", 32'(b0.out_err), 32'd1);
        b0.in_valid = 1'b0;
        b0.err_clr  = 1'b0;
        tick();
        check("clr_vs_set_drain", 32'(b0.out_valid), 32'd0);
        check("sticky_holds",     32'(b0.sel_err), 32'd1);

        // Full throughput with per-cycle data changes
        b0.in_valid  = 1'b1;
        b0.out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            logic [7:0] c0;
            logic [7:0] c1;
            logic [7:0] c2;
            c0 = 8'(i + 100);
            c1 = 8'(i * 7);
            c2 = 8'(i + 3);
            b0.d = {c2, c1, c0};
            b0.s = 2'(i % 3);
            case (i % 3)
                0:       exp_q.push_back(c0);
                1:       exp_q.push_back(c1);
                default: exp_q.push_back(c2);
            endcase
            tick();
            check("tp_valid", 32'(b0.out_valid), 32'd1);
            check("tp_ready", 32'(b0.in_ready), 32'd1);
            check("tp_y", 32'(b0.y), 32'(exp_q.pop_front()));
        end
        b0.in_valid = 1'b0;
        tick();
        check("tp_drain", 32'(b0.out_valid), 32'd0);
        check("tp_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset mid-stream with a full buffer
        idle_u0();
        b0.err_clr = 1'b1;
        tick();
        b0.err_clr  = 1'b0;
        b0.in_valid = 1'b1;
        b0.s = 2'd0; tick();
        b0.s = 2'd1; tick();
        check("mid_full_ready", 32'(b0.in_ready), 32'd0);
        b0.in_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("mid_rst_valid", 32'(b0.out_valid), 32'd0);
        check("mid_rst_y",     32'(b0.y), 32'd0);
        check("mid_rst_ready", 32'(b0.in_ready), 32'd1);
        #1 reset = 1'b1;
        b0.in_valid = 1'b1;
        b0.s = 2'd2;
        tick();
        check("mid_after_y",     32'(b0.y), 32'd2);
        check("mid_after_valid", 32'(b0.out_valid), 32'd1);
        check("mid_after_ready", 32'(b0.in_ready), 32'd1);
        b0.in_valid  = 1'b0;
        b0.out_ready = 1'b1;
        tick();
        check("mid_after_only", 32'(b0.out_valid), 32'd0);

        // Wide instance: WIDTH=16, N=5
        idle_u0();
        b1.out_ready = 1'b1;
        b1.in_valid  = 1'b1;
        b1.s = 3'd4; tick();
        check("w_y4",   32'(b1.y), 32'h4444);
        check("w_err4", 32'(b1.out_err), 32'd0);
        b1.s = 3'd5; tick();
        check("w_y5",       32'(b1.y), 32'd0);
        check("w_err5",     32'(b1.out_err), 32'd1);
        check("w_sel_err5", 32'(b1.sel_err), 32'd1);
        b1.s = 3'd7; tick();
        check("w_y7",   32'(b1.y), 32'd0);
        check("w_err7", 32'(b1.out_err), 32'd1);
        b1.s = 3'd1; tick();
        check("w_y1",   32'(b1.y), 32'h1111);
        check("w_err1", 32'(b1.out_err), 32'd0);
        b1.in_valid = 1'b0;
        b1.err_clr  = 1'b1;
        tick();
        check("w_clr",   32'(b1.sel_err), 32'd0);
        check("w_empty", 32'(b1.out_valid), 32'd0);
        b1.err_clr   = 1'b0;
        b1.out_ready = 1'b0;
        b1.in_valid  = 1'b1;
        b1.s = 3'd3; tick();
        b1.s = 3'd6; tick();
        check("w_full_ready", 32'(b1.in_ready), 32'd0);
        check("w_full_y",     32'(b1.y), 32'h3333);
        check("w_full_sel",   32'(b1.sel_err), 32'd1);
        b1.in_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("w_rst_valid", 32'(b1.out_valid), 32'd0);
        check("w_rst_sel",   32'(b1.sel_err), 32'd0);
        check("w_rst_ready", 32'(b1.in_ready), 32'd1);
        #1 reset = 1'b1;
        b1.in_valid = 1'b1;
        b1.s = 3'd2;
        tick();
        check("w_after_y",   32'(b1.y), 32'h2222);
        check("w_after_err", 32'(b1.out_err), 32'd0);
        b1.in_valid  = 1'b0;
        b1.out_ready = 1'b1;
        tick();
        check("w_after_only", 32'(b1.out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
